// File: rtl/vector_ram_if_arbiter.sv
// N-to-1 arbiter for a shared vector RAM port: round-robin request grant with
// stall locking, plus an in-order tag FIFO that routes read responses back.
module vector_ram_if_arbiter #(
    parameter int unsigned NUM_IN          = 4,
    parameter int unsigned PARALLELISM     = 4,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH      = 16,
    parameter int unsigned MAX_OUTSTANDING = 8
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [NUM_IN-1:0]                          s_valid,
    output logic [NUM_IN-1:0]                          s_ready,
    input  logic [NUM_IN-1:0]                          s_write,
    input  logic [NUM_IN*PARALLELISM*ADDR_WIDTH-1:0]   s_addr,
    input  logic [NUM_IN*PARALLELISM*DATA_WIDTH-1:0]   s_wdata,
    output logic [NUM_IN-1:0]                          s_rvalid,
    input  logic [NUM_IN-1:0]                          s_rready,
    output logic [PARALLELISM*DATA_WIDTH-1:0]          s_rdata,
    output logic                                       m_valid,
    input  logic                                       m_ready,
    output logic                                       m_write,
    output logic [PARALLELISM*ADDR_WIDTH-1:0]          m_addr,
    output logic [PARALLELISM*DATA_WIDTH-1:0]          m_wdata,
    input  logic                                       m_rvalid,
    output logic                                       m_rready,
    input  logic [PARALLELISM*DATA_WIDTH-1:0]          m_rdata
);
    localparam int unsigned IDX_W   = $clog2(NUM_IN);
    localparam int unsigned PTR_W   = $clog2(MAX_OUTSTANDING);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned BEAT_AW = PARALLELISM * ADDR_WIDTH;
    localparam int unsigned BEAT_DW = PARALLELISM * DATA_WIDTH;

    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] locked_idx_q, locked_idx_d;
    logic             lock_q, lock_d;
    logic [IDX_W-1:0] tag_mem_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic              fifo_full;
    logic              fifo_empty;
    logic [NUM_IN-1:0] eligible;
    logic              gnt_found;
    logic [IDX_W-1:0]  gnt_idx;
    logic [IDX_W-1:0]  cand;
    logic [IDX_W-1:0]  head_idx;
    logic              push;
    logic              pop;

    assign fifo_full  = (count_q == CNT_W'(MAX_OUTSTANDING));
    assign fifo_empty = (count_q == '0);
    assign eligible   = s_valid & (s_write | {NUM_IN{~fifo_full}});
    assign head_idx   = tag_mem_q[rd_ptr_q];

    // Locked grant wins; otherwise first eligible index starting at rr_ptr.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = locked_idx_q;
        cand      = '0;
        if (lock_q) begin
            gnt_found = s_valid[locked_idx_q];
        end else begin
            for (int unsigned k = 0; k < NUM_IN; k++) begin
                cand = IDX_W'((32'(rr_ptr_q) + k) % NUM_IN);
                if (!gnt_found && eligible[cand]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = cand;
                end
            end
        end
    end

    // Request mux and response routing; everything quiet while in reset.
    always_comb begin
        m_valid  = 1'b0;
        s_ready  = '0;
        m_write  = s_write[gnt_idx];
        m_addr   = s_addr[32'(gnt_idx) * BEAT_AW +: BEAT_AW];
        m_wdata  = s_wdata[32'(gnt_idx) * BEAT_DW +: BEAT_DW];
        s_rvalid = '0;
        m_rready = 1'b0;
        s_rdata  = m_rdata;
        if (!rst) begin
            m_valid = gnt_found;
            if (gnt_found) begin
                s_ready[gnt_idx] = m_ready;
            end
            if (!fifo_empty) begin
                s_rvalid[head_idx] = m_rvalid;
                m_rready           = s_rready[head_idx];
            end
        end
    end

    assign push = m_valid & m_ready & ~m_write;
    assign pop  = m_rvalid & m_rready;

    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        lock_d       = lock_q;
        locked_idx_d = locked_idx_q;
        wr_ptr_d     = wr_ptr_q + PTR_W'(push);
        rd_ptr_d     = rd_ptr_q + PTR_W'(pop);
        count_d      = count_q + CNT_W'(push) - CNT_W'(pop);
        if (m_valid) begin
            if (m_ready) begin
                rr_ptr_d = (gnt_idx == IDX_W'(NUM_IN - 1)) ? '0 : gnt_idx + IDX_W'(1);
                lock_d   = 1'b0;
            end else begin
                lock_d       = 1'b1;
                locked_idx_d = gnt_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q     <= '0;
            lock_q       <= 1'b0;
            locked_idx_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            lock_q       <= lock_d;
            locked_idx_q <= locked_idx_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // Tag storage needs no reset: occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem_q[wr_ptr_q] <= gnt_idx;
        end
    end
endmodule
